traceback_ctrl: RTL and testbench
=================================

Name: traceback_ctrl

Overview:
Survivor-path traceback controller for the Viterbi decoder. It sits directly downstream of the programmable start-pulse delay: the delayed pulse arrives on `start` once the ACS unit has filled enough survivor-memory columns. The block then walks the survivor RAM backwards from `wr_ptr` and emits decoded bits in reverse time order to the output LIFO.

Parameters:
STATE_W, 6, trellis state width (K-1); 2**STATE_W states
ADDR_W, 7, survivor RAM address width; RAM depth = 2**ADDR_W columns
TB_DEPTH, 32, traceback steps discarded before decoding starts
DEC_LEN, 32, decoded bits emitted per traceback run

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  global clock-enable; low = block fully frozen
start  in  1  single-cycle pulse from the delay stage requesting a traceback run
start_state  in  STATE_W  trellis state the traceback begins from (best or fixed state)
wr_ptr  in  ADDR_W  address of the most recently written survivor column
rd_en  out  1  survivor RAM read strobe
rd_addr  out  ADDR_W  survivor RAM read address
rd_data  in  2**STATE_W  decision vector; valid the cycle after rd_en
bit_out  out  1  decoded bit, reverse time order
bit_valid  out  1  qualifies bit_out
busy  out  1  traceback run in progress
done  out  1  one-cycle pulse with the last decoded bit
overrun  out  1  one-cycle pulse: start arrived while busy

Behaviour:
- Reset value: all outputs and internal registers are 0, and the FSM is in IDLE. Asynchronous reset mid-run aborts the run immediately; no partial bits are emitted afterwards.
- enable low: nothing updates (FSM, counters, state, and outputs hold their values). The survivor RAM read port is clocked by the same enable, so rd_data holds stable while stalled.
- All outputs are registered. FSM states are IDLE, RUN and DRAIN.
- IDLE: when start=1 (with enable=1), the block:
  - latches cur_state = start_state;
  - issues rd_en=1 with rd_addr = wr_ptr, visible the next cycle;
  - clears the step counter k;
  - moves to RUN.
- RUN: one read is issued per enabled cycle, and the address decrements by 1 modulo 2**ADDR_W (0 wraps to all-ones). Reads continue for L = TB_DEPTH + DEC_LEN in total. After the L-th read is issued, rd_en drops and the FSM moves to DRAIN.
- Data return, for step k at each cycle that rd_data is valid:
  - d = rd_data[cur_state];
  - cur_state becomes {cur_state[STATE_W-2:0], d};
  - if k >= TB_DEPTH, then bit_out = old cur_state[STATE_W-1] and bit_valid = 1 (registered);
  - k increments.
- DRAIN: consumes the final return (k = L-1), asserts done together with the last bit_valid, and returns to IDLE.
- Latency: with start sampled in cycle 0:
  - rd_en is high in cycles 1..L;
  - the bit for step k is visible in cycle 3+k;
  - bit_valid is high in cycles 3+TB_DEPTH .. L+2;
  - done is high in cycle L+2;
  - busy is high in cycles 1..L+1 (busy = FSM not IDLE).
- A new start is accepted in any cycle where busy=0, including the cycle in which done is high.
- start while busy: it is ignored and overrun pulses for 1 cycle. The current run is unaffected.
- Width rules:
  - the rd_addr decrement is ADDR_W-bit wrap-around;
  - k is wide enough for L;
  - rd_data indexing uses cur_state as an unsigned index.

Test Plan:
Bench parameters: STATE_W=3, ADDR_W=4, TB_DEPTH=4, DEC_LEN=4.
- Basic run: all-ones decisions, start_state=3'b000, wr_ptr=9, start in cycle 0 -> rd_addr 9,8,7..2 in cycles 1..8; states 001,011,111,...; bit_out=1,1,1,1 in cycles 7..10; done in cycle 10; busy in cycles 1..9.
- Wrap-around: wr_ptr=2 -> rd_addr sequence 2,1,0,15,14,13,12,11.
- Traceback path: decisions all 0, start_state=3'b101 -> discarded MSBs 1,0,1,0; emitted bits 0,0,0,0.
- Stall: enable held low for 3 cycles during RUN -> outputs frozen; the bit sequence is identical, shifted by 3 cycles.
- Collisions: start in cycle 5 -> overrun=1 for one cycle and the run is unchanged; start in cycle 10 (same cycle as done) -> new run accepted with rd_en=1 in cycle 11.
- Reset at cycle 6 -> all outputs 0 next cycle and IDLE; a following start behaves as a fresh run.

Source files
------------

// File: rtl/traceback_ctrl.sv
// Purpose : Viterbi survivor-path traceback. Walks the survivor RAM backwards from wr_ptr
//           and emits decoded bits, in reverse time order, towards the output LIFO.
// Latency : start in cycle 0 -> rd_en cycles 1..L, bit for step k in cycle 3+k, done in cycle L+2.
// Backpr. : none downstream; enable=0 freezes the whole block, and a start while busy is dropped
//           with a one-cycle overrun pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              global clock-enable (also gates the survivor RAM read port)
//   start               single-cycle request for a traceback run
//   start_state         trellis state the traceback begins from
//   wr_ptr              address of the most recently written survivor column
//   rd_en, rd_addr      survivor RAM read strobe / address
//   rd_data             decision vector, valid the enabled cycle after rd_en
//   bit_out, bit_valid  decoded bit stream (reverse time order)
//   busy                run in progress (FSM not IDLE)
//   done                one-cycle pulse together with the last decoded bit
//   overrun             one-cycle pulse when start arrives while busy

module traceback_ctrl #(
    parameter int STATE_W  = 6,
    parameter int ADDR_W   = 7,
    parameter int TB_DEPTH = 32,
    parameter int DEC_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic [STATE_W-1:0]    start_state,
    input  logic [ADDR_W-1:0]     wr_ptr,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [2**STATE_W-1:0] rd_data,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    // Total reads per run; the first TB_DEPTH returns only converge the path.
    localparam int L   = TB_DEPTH + DEC_LEN;
    localparam int K_W = $clog2(L + 1);

    localparam logic [K_W-1:0] L_K      = K_W'(L);
    localparam logic [K_W-1:0] LAST_K   = K_W'(L - 1);
    localparam logic [K_W-1:0] TB_DEP_K = K_W'(TB_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Read-issue side
    logic [K_W-1:0]     rd_cnt, rd_cnt_nxt;     // reads issued so far in this run
    logic               rd_en_nxt;
    logic [ADDR_W-1:0]  rd_addr_nxt;

    // Data-return side
    logic               data_vld, data_vld_nxt; // rd_data carries a decision vector this cycle
    logic [K_W-1:0]     k, k_nxt;               // traceback step of the current return
    logic [STATE_W-1:0] cur_state, cur_state_nxt;
    logic               dec;                    // survivor decision for cur_state

    // Registered outputs
    logic bit_out_nxt, bit_valid_nxt, busy_nxt, done_nxt, overrun_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            // rd_cnt == L means the L-th read is on the bus right now.
            RUN:     if (rd_cnt == L_K) state_nxt = DRAIN;
            // DRAIN only absorbs the final return, always exactly one enabled cycle.
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    assign dec = rd_data[cur_state];

    always_comb begin
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = rd_addr;
        rd_cnt_nxt    = rd_cnt;
        overrun_nxt   = 1'b0;

        cur_state_nxt = cur_state;
        k_nxt         = k;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = 1'b0;
        done_nxt      = 1'b0;

        // A read issued this cycle returns on the next enabled cycle.
        data_vld_nxt  = rd_en;
        busy_nxt      = (state_nxt != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    rd_en_nxt     = 1'b1;
                    rd_addr_nxt   = wr_ptr;
                    rd_cnt_nxt    = K_W'(1);
                    cur_state_nxt = start_state;
                    k_nxt         = '0;
                end
            end
            RUN: begin
                if (rd_cnt != L_K) begin
                    rd_en_nxt   = 1'b1;
                    // Natural ADDR_W-bit wrap: column 0 is followed by the all-ones column.
                    rd_addr_nxt = rd_addr - ADDR_W'(1);
                    rd_cnt_nxt  = rd_cnt + K_W'(1);
                end
                overrun_nxt = start;
            end
            DRAIN: begin
                overrun_nxt = start;
            end
            default: begin
                overrun_nxt = 1'b0;
            end
        endcase

        // Returns never coincide with an accepted start: the previous run has
        // fully drained (data_vld low) by the time the FSM is back in IDLE.
        if (data_vld) begin
            // Going back in time, the predecessor state is the current state
            // shifted left with the survivor decision entering at the LSB; the
            // bit that falls out of the MSB is the decoded input bit.
            cur_state_nxt = {cur_state[STATE_W-2:0], dec};
            k_nxt         = k + K_W'(1);
            if (k >= TB_DEP_K) begin
                bit_out_nxt   = cur_state[STATE_W-1];
                bit_valid_nxt = 1'b1;
            end
            if (k == LAST_K) begin
                done_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
            data_vld  <= 1'b0;
            k         <= '0;
            cur_state <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else if (enable) begin
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            rd_cnt    <= rd_cnt_nxt;
            data_vld  <= data_vld_nxt;
            k         <= k_nxt;
            cur_state <= cur_state_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= bit_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_traceback_ctrl.sv
// Purpose : directed bench for traceback_ctrl with a small survivor RAM model.
// Latency : cycle n = interval after the n-th rising edge; inputs driven and outputs sampled 1 unit after it.
// Backpr. : enable is toggled by the bench to exercise stalls.

module tb_traceback_ctrl;

    localparam int SW  = 3;
    localparam int AW  = 4;
    localparam int TBD = 4;
    localparam int DL  = 4;
    localparam int L   = TBD + DL;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           start;
    logic [SW-1:0]  start_state;
    logic [AW-1:0]  wr_ptr;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data = 8'h00;
    logic           bit_out;
    logic           bit_valid;
    logic           busy;
    logic           done;
    logic           overrun;

    logic [7:0]     ram [16];

    int checks = 0;
    int errors = 0;

    traceback_ctrl #(
        .STATE_W  (SW),
        .ADDR_W   (AW),
        .TB_DEPTH (TBD),
        .DEC_LEN  (DL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .start_state (start_state),
        .wr_ptr      (wr_ptr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Survivor RAM read port, clocked by the same enable as the DUT.
    always @(posedge clk) begin
        if (enable && rd_en) rd_data <= ram[rd_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},     rd_en,     0);
        chk({tag, "_rd_addr"},   rd_addr,   0);
        chk({tag, "_bit_out"},   bit_out,   0);
        chk({tag, "_bit_valid"}, bit_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_overrun"},   overrun,   0);
    endtask

    task automatic fill_ram(input logic [7:0] v);
        for (int i = 0; i < 16; i++) ram[i] = v;
    endtask

    // One complete run started in the current cycle (cycle 0). enable is low
    // in cycles st_at .. st_at+st_len-1, which freezes the logical timeline.
    // bits[i] is the i-th emitted bit (traceback step TBD+i).
    task automatic run(input string tag, input logic [AW-1:0] wp, input logic [SW-1:0] ss,
                       input logic [3:0] bits, input int st_at, input int st_len);
        int lc;
        logic en_c;
        logic exp_en;
        logic exp_bv;
        logic [AW-1:0] ea;
        wr_ptr      = wp;
        start_state = ss;
        start       = 1'b1;
        lc          = 0;
        for (int r = 1; r <= L + 3 + st_len; r++) begin
            en_c   = !((r - 1) >= st_at && (r - 1) < st_at + st_len);
            enable = en_c;
            step();
            start = 1'b0;
            if (en_c) lc++;
            exp_en = (lc >= 1 && lc <= L);
            ea     = wp - AW'(lc - 1);
            chk($sformatf("%s_c%0d_rd_en", tag, r), rd_en, exp_en);
            if (exp_en) chk($sformatf("%s_c%0d_rd_addr", tag, r), rd_addr, ea);
            chk($sformatf("%s_c%0d_busy", tag, r), busy, (lc >= 1 && lc <= L + 1));
            exp_bv = (lc >= 3 + TBD && lc <= L + 2);
            chk($sformatf("%s_c%0d_bit_valid", tag, r), bit_valid, exp_bv);
            if (exp_bv) chk($sformatf("%s_c%0d_bit_out", tag, r), bit_out, bits[lc - 3 - TBD]);
            chk($sformatf("%s_c%0d_done", tag, r), done, (lc == L + 2));
            chk($sformatf("%s_c%0d_overrun", tag, r), overrun, 0);
        end
        enable = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        start       = 1'b0;
        start_state = '0;
        wr_ptr      = '0;
        fill_ram(8'h00);

        // Reset state
        step();
        chk_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Basic run: all-ones decisions, start state 000, wr_ptr 9
        fill_ram(8'hFF);
        run("basic", 4'd9, 3'b000, 4'b1111, 1000, 0);

        // Address wrap-around: 2,1,0,15,14,13,12,11
        run("wrap", 4'd2, 3'b000, 4'b1111, 1000, 0);

        // Traceback path with all-zero decisions from 101: emitted bits all 0
        fill_ram(8'h00);
        run("zeros", 4'd5, 3'b101, 4'b0000, 1000, 0);

        // Mixed decisions from state 110, wr_ptr 7:
        // states 110,101,010,101,010,101,010,101 -> emitted 0,1,0,1
        fill_ram(8'h00);
        ram[7] = 8'b0100_0000;
        ram[6] = 8'b1101_1111;
        ram[5] = 8'b0000_0100;
        ram[4] = 8'b1101_1111;
        ram[3] = 8'b0000_0100;
        ram[2] = 8'b1101_1111;
        ram[1] = 8'b0000_0100;
        ram[0] = 8'b0010_0000;
        run("mixed", 4'd7, 3'b110, 4'b1010, 1000, 0);

        // Same run with enable low in cycles 8..10 (RUN, bits already flowing)
        run("stall", 4'd7, 3'b110, 4'b1010, 8, 3);

        // Collisions: start while busy (cycle 5) and start on the done cycle (cycle 10)
        fill_ram(8'hFF);
        wr_ptr      = 4'd9;
        start_state = 3'b000;
        start       = 1'b1;
        step();                 // cycle 1
        start = 1'b0;
        step(); step(); step(); step();  // cycle 5
        start  = 1'b1;
        wr_ptr = 4'd3;
        step();                 // cycle 6
        start = 1'b0;
        chk("coll_c6_overrun", overrun, 1);
        chk("coll_c6_rd_en",   rd_en,   1);
        chk("coll_c6_rd_addr", rd_addr, 4);
        chk("coll_c6_busy",    busy,    1);
        step();                 // cycle 7
        chk("coll_c7_overrun",   overrun,   0);
        chk("coll_c7_rd_addr",   rd_addr,   3);
        chk("coll_c7_bit_valid", bit_valid, 1);
        chk("coll_c7_bit_out",   bit_out,   1);
        step();                 // cycle 8
        chk("coll_c8_rd_addr", rd_addr, 2);
        step();                 // cycle 9
        chk("coll_c9_rd_en", rd_en, 0);
        chk("coll_c9_busy",  busy,  1);
        step();                 // cycle 10
        chk("coll_c10_done",      done,      1);
        chk("coll_c10_bit_valid", bit_valid, 1);
        chk("coll_c10_busy",      busy,      0);
        start  = 1'b1;
        wr_ptr = 4'd12;
        step();                 // cycle 11: new run
        start = 1'b0;
        chk("coll_c11_rd_en",     rd_en,     1);
        chk("coll_c11_rd_addr",   rd_addr,   12);
        chk("coll_c11_busy",      busy,      1);
        chk("coll_c11_overrun",   overrun,   0);
        chk("coll_c11_done",      done,      0);
        chk("coll_c11_bit_valid", bit_valid, 0);
        repeat (9) step();      // cycle 20
        chk("coll_c20_done",    done,    1);
        chk("coll_c20_bit_out", bit_out, 1);
        step();
        chk("coll_c21_busy",      busy,      0);
        chk("coll_c21_bit_valid", bit_valid, 0);

        // Reset mid-run at cycle 6, then a fresh run
        wr_ptr      = 4'd9;
        start_state = 3'b000;
        start       = 1'b1;
        step();                 // cycle 1
        start = 1'b0;
        repeat (5) step();      // cycle 6
        chk("rst_c6_rd_en_before", rd_en, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        step();                 // cycle 7
        chk_all_zero("rst_c7");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rst_after%0d_bit_valid", i), bit_valid, 0);
            chk($sformatf("rst_after%0d_busy", i), busy, 0);
            chk($sformatf("rst_after%0d_rd_en", i), rd_en, 0);
            chk($sformatf("rst_after%0d_done", i), done, 0);
        end
        run("fresh", 4'd9, 3'b000, 4'b1111, 1000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
